// File: rtl/video_coord_tracker.sv
`default_nettype none
// ============================================================================
// Module   : video_coord_tracker
// Purpose  : Passive pixel-coordinate tracker for an AXI-Stream video bus
//            (tuser = start of frame, tlast = end of line). Snoops the
//            valid/ready handshake and reports the x/y of the beat currently
//            presented, the frame count, the measured geometry of each closed
//            frame and single-cycle stream-framing error pulses.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            i_valid, i_ready         snooped handshake (never driven here)
//            i_sof, i_eol             tuser / tlast of the presented beat
//            o_x, o_y                 coordinate of presented beat (comb.)
//            o_frame_cnt              frames started since reset (wraps)
//            o_frame_done             pulse: previous frame closed
//            o_frame_width/_height    geometry of the last closed frame
//            o_err_no_sof             pulse: beat accepted while awaiting sof
//            o_err_line_len           pulse: line length != first line length
//            o_err_part_line          pulse: sof arrived mid-line
//            o_err_overflow           pulse: x or y counter saturated
// Revision : 1.0 - initial release
// ============================================================================
module video_coord_tracker #(
  parameter int CW = 16,
  parameter int FW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_ready,
  input  logic          i_sof,
  input  logic          i_eol,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic [FW-1:0] o_frame_cnt,
  output logic          o_frame_done,
  output logic [CW-1:0] o_frame_width,
  output logic [CW-1:0] o_frame_height,
  output logic          o_err_no_sof,
  output logic          o_err_line_len,
  output logic          o_err_part_line,
  output logic          o_err_overflow
);

  typedef enum logic [0:0] {
    S_WAIT_SOF = 1'b0,
    S_ACTIVE   = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_MAX = {CW{1'b1}};

  state_t        r_state;
  logic [CW-1:0] r_x_cnt;
  logic [CW-1:0] r_y_cnt;
  logic [CW-1:0] r_width_lat;
  logic          r_first_line;
  logic [FW-1:0] r_frame_cnt;
  logic          r_frame_done;
  logic [CW-1:0] r_frame_width;
  logic [CW-1:0] r_frame_height;
  logic          r_err_no_sof;
  logic          r_err_line_len;
  logic          r_err_part_line;
  logic          r_err_overflow;

  state_t        w_state_nxt;
  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic [CW-1:0] w_width_lat_nxt;
  logic          w_first_line_nxt;
  logic [FW-1:0] w_frame_cnt_nxt;
  logic          w_frame_done_nxt;
  logic [CW-1:0] w_frame_width_nxt;
  logic [CW-1:0] w_frame_height_nxt;
  logic          w_err_no_sof_nxt;
  logic          w_err_line_len_nxt;
  logic          w_err_part_line_nxt;
  logic          w_err_overflow_nxt;

  logic          w_beat;
  logic [CW:0]   w_line_len;
  logic [CW-1:0] w_len_sat;

  assign w_beat = i_valid & i_ready;

  // Line length is one wider than the counter so a full-scale line does not
  // wrap; it is clamped to the counter range before latching/comparing.
  assign w_line_len = {1'b0, r_x_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_len_sat  = w_line_len[CW] ? c_MAX : w_line_len[CW-1:0];

  // A sof beat is always column/row 0, whatever the counters hold.
  assign o_x = i_sof ? '0 : r_x_cnt;
  assign o_y = i_sof ? '0 : r_y_cnt;

  always_comb begin
    w_state_nxt         = r_state;
    w_x_nxt             = r_x_cnt;
    w_y_nxt             = r_y_cnt;
    w_width_lat_nxt     = r_width_lat;
    w_first_line_nxt    = r_first_line;
    w_frame_cnt_nxt     = r_frame_cnt;
    w_frame_done_nxt    = 1'b0;
    w_frame_width_nxt   = r_frame_width;
    w_frame_height_nxt  = r_frame_height;
    w_err_no_sof_nxt    = 1'b0;
    w_err_line_len_nxt  = 1'b0;
    w_err_part_line_nxt = 1'b0;
    w_err_overflow_nxt  = 1'b0;

    if (w_beat) begin
      if (i_sof) begin
        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
        w_state_nxt     = S_ACTIVE;
        // Only a frame that was actually opened can be closed and measured.
        if (r_state == S_ACTIVE) begin
          w_frame_done_nxt    = 1'b1;
          w_frame_width_nxt   = r_width_lat;
          w_frame_height_nxt  = r_y_cnt;
          w_err_part_line_nxt = (r_x_cnt != '0);
        end
        if (i_eol) begin
          // Single-pixel first line: it is complete on this very beat.
          w_x_nxt          = '0;
          w_y_nxt          = CW'(1);
          w_width_lat_nxt  = CW'(1);
          w_first_line_nxt = 1'b0;
        end else begin
          w_x_nxt          = CW'(1);
          w_y_nxt          = '0;
          w_width_lat_nxt  = '0;
          w_first_line_nxt = 1'b1;
        end
      end else if (r_state == S_WAIT_SOF) begin
        w_err_no_sof_nxt = 1'b1;
      end else if (i_eol) begin
        w_x_nxt = '0;
        if (r_y_cnt == c_MAX) begin
          w_err_overflow_nxt = 1'b1;
        end else begin
          w_y_nxt = r_y_cnt + CW'(1);
        end
        if (r_first_line) begin
          w_width_lat_nxt  = w_len_sat;
          w_first_line_nxt = 1'b0;
        end else if (w_len_sat != r_width_lat) begin
          w_err_line_len_nxt = 1'b1;
        end
      end else begin
        if (r_x_cnt == c_MAX) begin
          w_err_overflow_nxt = 1'b1;
        end else begin
          w_x_nxt = r_x_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_WAIT_SOF;
      r_x_cnt         <= '0;
      r_y_cnt         <= '0;
      r_width_lat     <= '0;
      r_first_line    <= 1'b0;
      r_frame_cnt     <= '0;
      r_frame_done    <= 1'b0;
      r_frame_width   <= '0;
      r_frame_height  <= '0;
      r_err_no_sof    <= 1'b0;
      r_err_line_len  <= 1'b0;
      r_err_part_line <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_x_cnt         <= w_x_nxt;
      r_y_cnt         <= w_y_nxt;
      r_width_lat     <= w_width_lat_nxt;
      r_first_line    <= w_first_line_nxt;
      r_frame_cnt     <= w_frame_cnt_nxt;
      r_frame_done    <= w_frame_done_nxt;
      r_frame_width   <= w_frame_width_nxt;
      r_frame_height  <= w_frame_height_nxt;
      r_err_no_sof    <= w_err_no_sof_nxt;
      r_err_line_len  <= w_err_line_len_nxt;
      r_err_part_line <= w_err_part_line_nxt;
      r_err_overflow  <= w_err_overflow_nxt;
    end
  end

  assign o_frame_cnt     = r_frame_cnt;
  assign o_frame_done    = r_frame_done;
  assign o_frame_width   = r_frame_width;
  assign o_frame_height  = r_frame_height;
  assign o_err_no_sof    = r_err_no_sof;
  assign o_err_line_len  = r_err_line_len;
  assign o_err_part_line = r_err_part_line;
  assign o_err_overflow  = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_video_coord_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_coord_tracker
// Purpose  : Self-checking bench for video_coord_tracker. Directed beats push
//            their expected coordinate into a queue; registered pulses push an
//            expected event record. Monitors pop and compare whenever the DUT
//            presents a beat or raises any pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_coord_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic valid = 1'b0;
  logic ready = 1'b0;
  logic sof   = 1'b0;
  logic eol   = 1'b0;

  logic [15:0] o_x, o_y, o_frame_cnt, o_frame_width, o_frame_height;
  logic        o_frame_done, o_err_no_sof, o_err_line_len, o_err_part_line, o_err_overflow;

  // Narrow instance used for the saturation case.
  logic v4 = 1'b0;
  logic s4 = 1'b0;
  logic e4 = 1'b0;
  logic [3:0]  x4, y4, fw4, fh4;
  logic [15:0] fc4;
  logic        fd4, ens4, ell4, epl4, eov4;

  video_coord_tracker #(.CW(16), .FW(16)) dut (
    .clk(clk), .rst(rst), .i_valid(valid), .i_ready(ready), .i_sof(sof), .i_eol(eol),
    .o_x(o_x), .o_y(o_y), .o_frame_cnt(o_frame_cnt), .o_frame_done(o_frame_done),
    .o_frame_width(o_frame_width), .o_frame_height(o_frame_height),
    .o_err_no_sof(o_err_no_sof), .o_err_line_len(o_err_line_len),
    .o_err_part_line(o_err_part_line), .o_err_overflow(o_err_overflow)
  );

  video_coord_tracker #(.CW(4), .FW(16)) dut4 (
    .clk(clk), .rst(rst), .i_valid(v4), .i_ready(1'b1), .i_sof(s4), .i_eol(e4),
    .o_x(x4), .o_y(y4), .o_frame_cnt(fc4), .o_frame_done(fd4),
    .o_frame_width(fw4), .o_frame_height(fh4),
    .o_err_no_sof(ens4), .o_err_line_len(ell4),
    .o_err_part_line(epl4), .o_err_overflow(eov4)
  );

  typedef struct { int x; int y; } coord_t;
  // bits = {frame_done, err_no_sof, err_line_len, err_part_line, err_overflow}
  typedef struct { logic [4:0] bits; int w; int h; } ev_t;

  localparam logic [4:0] c_NOSOF = 5'b01000;
  localparam logic [4:0] c_LEN   = 5'b00100;
  localparam logic [4:0] c_OVF   = 5'b00001;

  coord_t qc[$];
  coord_t qc4[$];
  ev_t    qe[$];
  ev_t    qe4[$];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_w  = 0;
  int exp_h  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  coord_t     mc, mc4;
  ev_t        me, me4;
  logic [4:0] pulses, pulses4;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        if (qc.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          mc = qc.pop_front();
          chk("x", {48'd0, o_x}, mc.x);
          chk("y", {48'd0, o_y}, mc.y);
        end
      end
      pulses = {o_frame_done, o_err_no_sof, o_err_line_len, o_err_part_line, o_err_overflow};
      if (pulses != 5'b0) begin
        if (qe.size() == 0) chk("unexpected_pulse", {59'd0, pulses}, 0);
        else begin
          me = qe.pop_front();
          chk("pulses", {59'd0, pulses}, {59'd0, me.bits});
          chk("frame_width", {48'd0, o_frame_width}, me.w);
          chk("frame_height", {48'd0, o_frame_height}, me.h);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (v4) begin
        if (qc4.size() == 0) chk("unexpected_beat4", 1, 0);
        else begin
          mc4 = qc4.pop_front();
          chk("x4", {60'd0, x4}, mc4.x);
          chk("y4", {60'd0, y4}, mc4.y);
        end
      end
      pulses4 = {fd4, ens4, ell4, epl4, eov4};
      if (pulses4 != 5'b0) begin
        if (qe4.size() == 0) chk("unexpected_pulse4", {59'd0, pulses4}, 0);
        else begin
          me4 = qe4.pop_front();
          chk("pulses4", {59'd0, pulses4}, {59'd0, me4.bits});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic e, input int ex, input int ey);
    coord_t c;
    c.x = ex; c.y = ey;
    qc.push_back(c);
    valid = 1'b1; ready = 1'b1; sof = s; eol = e;
    @(posedge clk); #1;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic drive4(input logic s, input logic e, input int ex, input int ey);
    coord_t c;
    c.x = ex; c.y = ey;
    qc4.push_back(c);
    v4 = 1'b1; s4 = s; e4 = e;
    @(posedge clk); #1;
    v4 = 1'b0; s4 = 1'b0; e4 = 1'b0;
  endtask

  task automatic ev(input logic [4:0] bits);
    ev_t e;
    e.bits = bits; e.w = exp_w; e.h = exp_h;
    qe.push_back(e);
  endtask

  task automatic ev_done(input int w, input int h, input logic part);
    exp_w = w; exp_h = h;
    ev({1'b1, 2'b00, part, 1'b0});
  endtask

  task automatic chk_frame_cnt(input int exp);
    @(negedge clk);
    chk("frame_cnt", {48'd0, o_frame_cnt}, exp);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ev_t e4;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_x", {48'd0, o_x}, 0);
    chk("rst_y", {48'd0, o_y}, 0);
    chk("rst_frame_cnt", {48'd0, o_frame_cnt}, 0);
    chk("rst_frame_width", {48'd0, o_frame_width}, 0);
    chk("rst_frame_height", {48'd0, o_frame_height}, 0);
    chk("rst_pulses", {59'd0, o_frame_done, o_err_no_sof, o_err_line_len,
                       o_err_part_line, o_err_overflow}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T5: beats before the first sof, then the opening sof beat
    ev(c_NOSOF); drive(1'b0, 1'b0, 0, 0);
    ev(c_NOSOF); drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    chk_frame_cnt(1);

    // T1 (4x3 frame) with a T2 stall inside line 0
    drive(1'b0, 1'b0, 1, 0);
    valid = 1'b1; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_x", {48'd0, o_x}, 2);
      chk("stall_y", {48'd0, o_y}, 0);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    drive(1'b0, 1'b0, 2, 0);
    drive(1'b0, 1'b1, 3, 0);
    for (int yy = 1; yy < 3; yy++)
      for (int xx = 0; xx < 4; xx++)
        drive(1'b0, xx == 3, xx, yy);
    ev_done(4, 3, 1'b0);
    drive(1'b1, 1'b0, 0, 0);
    chk_frame_cnt(2);

    // T3: line lengths 4,4,3
    drive(1'b0, 1'b0, 1, 0); drive(1'b0, 1'b0, 2, 0); drive(1'b0, 1'b1, 3, 0);
    for (int xx = 0; xx < 4; xx++) drive(1'b0, xx == 3, xx, 1);
    drive(1'b0, 1'b0, 0, 2); drive(1'b0, 1'b0, 1, 2);
    ev(c_LEN);
    drive(1'b0, 1'b1, 2, 2);

    // T6: close the 4,4,3 frame, then sof arriving mid line 1
    ev_done(4, 3, 1'b0);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1, 0); drive(1'b0, 1'b0, 2, 0); drive(1'b0, 1'b1, 3, 0);
    drive(1'b0, 1'b0, 0, 1); drive(1'b0, 1'b0, 1, 1);
    ev_done(4, 1, 1'b1);
    drive(1'b1, 1'b0, 0, 0);
    chk_frame_cnt(4);

    // T6: reset mid-frame
    drive(1'b0, 1'b0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_x", {48'd0, o_x}, 0);
    chk("midrst_y", {48'd0, o_y}, 0);
    chk("midrst_frame_cnt", {48'd0, o_frame_cnt}, 0);
    chk("midrst_frame_width", {48'd0, o_frame_width}, 0);
    chk("midrst_frame_height", {48'd0, o_frame_height}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_w = 0; exp_h = 0;

    // T4: sof+eol on every beat
    drive(1'b1, 1'b1, 0, 0);
    ev_done(1, 1, 1'b0); drive(1'b1, 1'b1, 0, 0);
    ev_done(1, 1, 1'b0); drive(1'b1, 1'b1, 0, 0);
    chk_frame_cnt(3);

    // T6: 17-pixel line on the CW=4 instance
    drive4(1'b1, 1'b0, 0, 0);
    for (int i = 1; i < 15; i++) drive4(1'b0, 1'b0, i, 0);
    e4.bits = c_OVF; e4.w = 0; e4.h = 0;
    qe4.push_back(e4);
    drive4(1'b0, 1'b0, 15, 0);
    drive4(1'b0, 1'b1, 15, 0);
    @(negedge clk);
    chk("ovf_after_eol_x4", {60'd0, x4}, 0);
    chk("ovf_after_eol_y4", {60'd0, y4}, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("coord_queue_drained", qc.size(), 0);
    chk("event_queue_drained", qe.size(), 0);
    chk("coord4_queue_drained", qc4.size(), 0);
    chk("event4_queue_drained", qe4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
